// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } vend_state_e;

    localparam int DEF_CREDIT_W = 8;
    localparam int DEF_COIN_W   = 4;
    localparam int PRICE_VEC_W  = 1024;

    // Extracts price slice idx (w bits wide) from the packed price vector.
    function automatic logic [31:0] price_slice(input logic [PRICE_VEC_W-1:0] prices,
                                                input int idx, input int w);
        logic [PRICE_VEC_W-1:0] sh;
        logic [31:0]            mask;
        sh   = prices >> (idx * w);
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return sh[31:0] & mask;
    endfunction

endpackage

// File: rtl/vending_fsm_sel_decode.sv
// Button decoder: flags a single pressed button, multiple presses, and the pressed index.
module sel_decode #(
    parameter int N_PRODUCTS = 2,
    parameter int IDX_W      = 1
) (
    input  logic [N_PRODUCTS-1:0] sel,
    output logic                  valid_onehot,
    output logic                  multi_error,
    output logic [IDX_W-1:0]      index
);

    int pressed;

    always_comb begin
        pressed = 0;
        index   = '0;
        for (int i = 0; i < N_PRODUCTS; i++) begin
            if (sel[i]) begin
                pressed = pressed + 1;
                index   = IDX_W'(i);
            end
        end
        valid_onehot = (pressed == 1);
        multi_error  = (pressed > 1);
    end

endmodule

// File: rtl/vending_fsm.sv
// Vending controller: coin credit, one-hot product selection, dispense and change.
// Optional idle-credit refund timer enabled with `define VEND_TIMEOUT_EN.
module vending_fsm
    import vend_pkg::*;
#(
    parameter int N_PRODUCTS = 2,
    parameter int CREDIT_W   = DEF_CREDIT_W,
    parameter int COIN_W     = DEF_COIN_W,
    parameter int MAX_CREDIT = 200,
    parameter logic [N_PRODUCTS*CREDIT_W-1:0] PRICES = {8'd3, 8'd5}
`ifdef VEND_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 1000
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  coin_valid,
    input  logic [COIN_W-1:0]     coin_value,
    input  logic [N_PRODUCTS-1:0] sel,
    input  logic                  cancel,
    output logic [N_PRODUCTS-1:0] dispense,
    output logic                  change_valid,
    output logic [CREDIT_W-1:0]   change_amount,
    output logic                  coin_reject,
    output logic                  sel_error,
    output logic [CREDIT_W-1:0]   credit,
    output logic                  busy
);

    localparam int IDX_W = (N_PRODUCTS > 1) ? $clog2(N_PRODUCTS) : 1;
    localparam logic [PRICE_VEC_W-1:0] PRICES_EXT = PRICE_VEC_W'(PRICES);

    logic [CREDIT_W-1:0] price_arr [N_PRODUCTS];

    for (genvar g = 0; g < N_PRODUCTS; g++) begin : g_price
        localparam int P = int'(price_slice(PRICES_EXT, g, CREDIT_W));
        assign price_arr[g] = CREDIT_W'(P);
        if (P == 0) begin : g_zero_price
            $error("vending_fsm: price of product %0d is zero", g);
        end
        if (P > MAX_CREDIT) begin : g_price_high
            $error("vending_fsm: price of product %0d exceeds MAX_CREDIT", g);
        end
    end

    if (longint'(MAX_CREDIT) >= (longint'(1) << CREDIT_W)) begin : g_max_credit_wide
        $error("vending_fsm: MAX_CREDIT does not fit in CREDIT_W bits");
    end
    if (COIN_W > CREDIT_W) begin : g_coin_wide
        $error("vending_fsm: COIN_W wider than CREDIT_W");
    end

    vend_state_e             state_q, state_d;
    logic [CREDIT_W-1:0]     credit_q, credit_d;
    logic [N_PRODUCTS-1:0]   dispense_q, dispense_d;
    logic                    change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0]     change_amount_q, change_amount_d;
    logic                    coin_reject_q, coin_reject_d;
    logic                    sel_error_q, sel_error_d;
    logic                    busy_q, busy_d;

    logic                    sel_onehot, sel_multi;
    logic [IDX_W-1:0]        sel_idx;
    logic [CREDIT_W-1:0]     sel_price;
    logic                    sel_take;
    logic [CREDIT_W:0]       coin_sum;
    logic                    coin_fits;
    logic                    timeout;

    sel_decode #(
        .N_PRODUCTS (N_PRODUCTS),
        .IDX_W      (IDX_W)
    ) u_sel_decode (
        .sel          (sel),
        .valid_onehot (sel_onehot),
        .multi_error  (sel_multi),
        .index        (sel_idx)
    );

    // One extra bit on the sum so an oversize coin cannot wrap into range.
    assign coin_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value);
    assign coin_fits = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign sel_price = price_arr[sel_idx];
    assign sel_take  = sel_onehot && (credit_q >= sel_price);

`ifdef VEND_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_clear;

    always_comb begin
        to_clear = (coin_valid && coin_fits) || (sel != '0);
        timeout  = 1'b0;
        cnt_d    = '0;
        if (state_q == CREDIT && !to_clear) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) timeout = 1'b1;
            else                                  cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        dispense_d      = '0;
        change_valid_d  = 1'b0;
        change_amount_d = '0;
        coin_reject_d   = 1'b0;
        sel_error_d     = 1'b0;
        unique case (state_q)
            IDLE, CREDIT: begin
                if (sel_take) begin
                    // A coin arriving with an accepted selection is returned.
                    state_d             = DISPENSE;
                    credit_d            = credit_q - sel_price;
                    dispense_d[sel_idx] = 1'b1;
                    coin_reject_d       = coin_valid;
                end else begin
                    sel_error_d = sel_onehot || sel_multi;
                    if (state_q == CREDIT && (cancel || timeout)) begin
                        state_d         = CHANGE;
                        change_valid_d  = 1'b1;
                        change_amount_d = credit_q;
                        credit_d        = '0;
                        coin_reject_d   = coin_valid;
                    end else if (coin_valid) begin
                        if (coin_fits) begin
                            credit_d = coin_sum[CREDIT_W-1:0];
                            state_d  = (coin_sum != '0) ? CREDIT : IDLE;
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                end
            end
            DISPENSE: begin
                coin_reject_d = coin_valid;
                if (credit_q != '0) begin
                    state_d         = CHANGE;
                    change_valid_d  = 1'b1;
                    change_amount_d = credit_q;
                    credit_d        = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                coin_reject_d = coin_valid;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == DISPENSE) || (state_d == CHANGE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            credit_q        <= '0;
            dispense_q      <= '0;
            change_valid_q  <= 1'b0;
            change_amount_q <= '0;
            coin_reject_q   <= 1'b0;
            sel_error_q     <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            dispense_q      <= dispense_d;
            change_valid_q  <= change_valid_d;
            change_amount_q <= change_amount_d;
            coin_reject_q   <= coin_reject_d;
            sel_error_q     <= sel_error_d;
            busy_q          <= busy_d;
        end
    end

    assign dispense      = dispense_q;
    assign change_valid  = change_valid_q;
    assign change_amount = change_amount_q;
    assign coin_reject   = coin_reject_q;
    assign sel_error     = sel_error_q;
    assign credit        = credit_q;
    assign busy          = busy_q;

endmodule
